reg_burst_writer: RTL and testbench

REG_BURST_WRITER -- requirements
Module: reg_burst_writer

---
 rtl/reg_burst_pkg.sv | 6 +
 rtl/reg_stepper.sv | 19 +
 rtl/reg_burst_writer.sv | 90 +++++++++
 tb/tb_reg_burst_writer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/reg_burst_pkg.sv
// reg_burst_pkg: shared state encoding and default sizing for the register burst writer
package reg_burst_pkg;
   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;
   localparam int DEF_NUM_REGS = 32;
   localparam int DEF_LEN_W = 6;
endpackage

// File: rtl/reg_stepper.sv
// reg_stepper: next register number and boundary detect for one burst step
//   regnum      - register written this cycle
//   direction   - 1 steps up, 0 steps down
//   wrap_en     - 1 lets the step wrap, so no boundary is ever reported
//   next_regnum - register for the following write
//   at_boundary - this write sits on the last register reachable without wrapping
module reg_stepper #(
   parameter int ADDR_W = 5
) (
   input  logic [ADDR_W-1:0] regnum,
   input  logic              direction,
   input  logic              wrap_en,
   output logic [ADDR_W-1:0] next_regnum,
   output logic              at_boundary
);
   // register count is a power of two, so plain modular arithmetic gives the wrap
   assign next_regnum = direction ? regnum + 1'b1 : regnum - 1'b1;
   assign at_boundary = !wrap_en && (direction ? &regnum : ~|regnum);
endmodule

// File: rtl/reg_burst_writer.sv
// reg_burst_writer: issues a burst of consecutive register-file writes
//   clock, reset           - rising-edge clock, synchronous active-low reset
//   go, direction, start_reg, length, wrap_en - burst request and its parameters, latched in IDLE
//   abort                  - stops a running burst, suppressing that cycle's write
//   wr_en, regnum          - regfile write port enable and address
//   busy, done, err, count - burst status
module reg_burst_writer import reg_burst_pkg::*; #(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int LEN_W = DEF_LEN_W,
   localparam int ADDR_W = $clog2(NUM_REGS)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              go,
   input  logic              direction,
   input  logic [ADDR_W-1:0] start_reg,
   input  logic [LEN_W-1:0]  length,
   input  logic              wrap_en,
   input  logic              abort,
   output logic              wr_en,
   output logic [ADDR_W-1:0] regnum,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [LEN_W-1:0]  count
);
   state_t state_q, state_d;
   logic dir_q, wrap_q, wr_q;
   logic [LEN_W-1:0] len_q, count_inc, count_d;
   logic [ADDR_W-1:0] nxt, regnum_d;
   logic bnd, last, fin, accept, wstep, err_d;

   reg_stepper #(.ADDR_W(ADDR_W)) u_step (
      .regnum(regnum),
      .direction(dir_q),
      .wrap_en(wrap_q),
      .next_regnum(nxt),
      .at_boundary(bnd)
   );

   assign count_inc = count + 1'b1;
   assign last = count_inc == len_q;
   assign fin = last || bnd;
   assign accept = state_q == S_IDLE && go;
   assign wstep = state_q == S_WRITE && !abort;
   // abort must kill the write in its own cycle, so it gates the registered enable
   assign wr_en = wr_q && !abort;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= S_IDLE;
         wr_q <= 1'b0;
         regnum <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         err <= 1'b0;
         count <= '0;
         dir_q <= 1'b0;
         wrap_q <= 1'b0;
         len_q <= '0;
      end else begin
         state_q <= state_d;
         wr_q <= state_d == S_WRITE;
         busy <= state_d != S_IDLE;
         done <= state_d == S_DONE;
         regnum <= regnum_d;
         err <= err_d;
         count <= count_d;
         if (accept) begin
            dir_q <= direction;
            wrap_q <= wrap_en;
            len_q <= length;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      if (accept) state_d = (length == '0) ? S_DONE : S_WRITE;
      else if (state_q == S_WRITE && (abort || fin)) state_d = S_DONE;
      else if (state_q == S_DONE) state_d = S_IDLE;
   end

   // regnum only advances while more writes follow, so it holds the last address written
   always_comb begin
      regnum_d = accept ? start_reg : (wstep && !fin) ? nxt : regnum;
      count_d = accept ? '0 : wstep ? count_inc : count;
      err_d = accept ? 1'b0 : (state_q == S_WRITE && abort) ? 1'b1 : (wstep && fin) ? (bnd && !last) : err;
   end
endmodule

// File: tb/tb_reg_burst_writer.sv
module tb_reg_burst_writer;
   logic clock = 1'b0;
   logic reset, go, direction, wrap_en, abort;
   logic [4:0] start_reg;
   logic [5:0] length;
   logic wr_en, busy, done, err;
   logic [4:0] regnum;
   logic [5:0] count;
   int checks = 0;
   int errors = 0;

   typedef struct {
      bit rst, g, dir, wrap, abt;
      int start, len;
      bit e_wr, e_busy, e_done, e_err;
      int e_reg, e_cnt;
   } vec_t;

   vec_t tbl[$];

   reg_burst_writer dut (
      .clock(clock), .reset(reset), .go(go), .direction(direction),
      .start_reg(start_reg), .length(length), .wrap_en(wrap_en), .abort(abort),
      .wr_en(wr_en), .regnum(regnum), .busy(busy), .done(done), .err(err), .count(count)
   );

   always #5 clock = ~clock;

   function automatic vec_t v(bit rst, bit g, bit dir, bit wrap, int start, int len, bit abt,
                              bit wr, int rg, bit bsy, bit dn, bit er, int cnt);
      vec_t r;
      r.rst = rst; r.g = g; r.dir = dir; r.wrap = wrap; r.start = start; r.len = len; r.abt = abt;
      r.e_wr = wr; r.e_reg = rg; r.e_busy = bsy; r.e_done = dn; r.e_err = er; r.e_cnt = cnt;
      return r;
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(int row, bit wr, int rg, bit bsy, bit dn, bit er, int cnt);
      chk($sformatf("r%0d wr_en", row), int'(wr_en), int'(wr));
      if (rg >= 0) chk($sformatf("r%0d regnum", row), int'(regnum), rg);
      chk($sformatf("r%0d busy", row), int'(busy), int'(bsy));
      chk($sformatf("r%0d done", row), int'(done), int'(dn));
      chk($sformatf("r%0d err", row), int'(err), int'(er));
      chk($sformatf("r%0d count", row), int'(count), cnt);
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   initial begin
      int writes, got_done;
      reset = 1'b0; go = 1'b0; direction = 1'b0; wrap_en = 1'b0; abort = 1'b0;
      start_reg = '0; length = '0;
      tick; tick;
      chk_all(-1, 0, 0, 0, 0, 0, 0);

      // down burst 5,4,3,2
      tbl.push_back(v(1,1,0,0,5,4,0, 0,0,0,0,0,0));
      tbl.push_back(v(1,0,0,0,0,0,0, 1,5,1,0,0,0));
      tbl.push_back(v(1,0,0,0,0,0,0, 1,4,1,0,0,1));
      tbl.push_back(v(1,0,0,0,0,0,0, 1,3,1,0,0,2));
      tbl.push_back(v(1,0,0,0,0,0,0, 1,2,1,0,0,3));
      tbl.push_back(v(1,0,0,0,0,0,0, 0,-1,1,1,0,4));
      tbl.push_back(v(1,0,0,0,0,0,0, 0,-1,0,0,0,4));
      // up burst with wrap 30,31,0,1
      tbl.push_back(v(1,1,1,1,30,4,0, 0,-1,0,0,0,4));
      tbl.push_back(v(1,0,0,0,0,0,0, 1,30,1,0,0,0));
      tbl.push_back(v(1,0,0,0,0,0,0, 1,31,1,0,0,1));
      tbl.push_back(v(1,0,0,0,0,0,0, 1,0,1,0,0,2));
      tbl.push_back(v(1,0,0,0,0,0,0, 1,1,1,0,0,3));
      tbl.push_back(v(1,0,0,0,0,0,0, 0,-1,1,1,0,4));
      tbl.push_back(v(1,0,0,0,0,0,0, 0,-1,0,0,0,4));
      // down without wrap hits register 0 early
      tbl.push_back(v(1,1,0,0,1,5,0, 0,-1,0,0,0,4));
      tbl.push_back(v(1,0,0,0,0,0,0, 1,1,1,0,0,0));
      tbl.push_back(v(1,0,0,0,0,0,0, 1,0,1,0,0,1));
      tbl.push_back(v(1,0,0,0,0,0,0, 0,-1,1,1,1,2));
      tbl.push_back(v(1,0,0,0,0,0,0, 0,-1,0,0,1,2));
      // abort in third write; go while busy ignored
      tbl.push_back(v(1,1,1,0,10,6,0, 0,-1,0,0,1,2));
      tbl.push_back(v(1,0,0,0,0,0,0, 1,10,1,0,0,0));
      tbl.push_back(v(1,1,0,0,20,1,0, 1,11,1,0,0,1));
      tbl.push_back(v(1,0,0,0,0,0,1, 0,12,1,0,0,2));
      tbl.push_back(v(1,1,0,0,20,3,0, 0,-1,1,1,1,2));
      tbl.push_back(v(1,0,0,0,0,0,0, 0,-1,0,0,1,2));
      tbl.push_back(v(1,0,0,0,0,0,0, 0,-1,0,0,1,2));
      // abort on the last write wins
      tbl.push_back(v(1,1,1,0,7,2,0, 0,-1,0,0,1,2));
      tbl.push_back(v(1,0,0,0,0,0,0, 1,7,1,0,0,0));
      tbl.push_back(v(1,0,0,0,0,0,1, 0,8,1,0,0,1));
      tbl.push_back(v(1,0,0,0,0,0,0, 0,-1,1,1,1,1));
      tbl.push_back(v(1,0,0,0,0,0,0, 0,-1,0,0,1,1));
      // ending exactly on register 31 without wrap is not an error
      tbl.push_back(v(1,1,1,0,30,2,0, 0,-1,0,0,1,1));
      tbl.push_back(v(1,0,0,0,0,0,0, 1,30,1,0,0,0));
      tbl.push_back(v(1,0,0,0,0,0,0, 1,31,1,0,0,1));
      tbl.push_back(v(1,0,0,0,0,0,0, 0,-1,1,1,0,2));
      tbl.push_back(v(1,0,0,0,0,0,0, 0,-1,0,0,0,2));
      // up without wrap starting at 31 stops after one write
      tbl.push_back(v(1,1,1,0,31,3,0, 0,-1,0,0,0,2));
      tbl.push_back(v(1,0,0,0,0,0,0, 1,31,1,0,0,0));
      tbl.push_back(v(1,0,0,0,0,0,0, 0,-1,1,1,1,1));
      tbl.push_back(v(1,0,0,0,0,0,0, 0,-1,0,0,1,1));
      // zero length: straight to done
      tbl.push_back(v(1,1,1,0,9,0,0, 0,-1,0,0,1,1));
      tbl.push_back(v(1,0,0,0,0,0,0, 0,-1,1,1,0,0));
      tbl.push_back(v(1,0,0,0,0,0,0, 0,-1,0,0,0,0));
      // down with wrap 0,31
      tbl.push_back(v(1,1,0,1,0,2,0, 0,-1,0,0,0,0));
      tbl.push_back(v(1,0,0,0,0,0,0, 1,0,1,0,0,0));
      tbl.push_back(v(1,0,0,0,0,0,0, 1,31,1,0,0,1));
      tbl.push_back(v(1,0,0,0,0,0,0, 0,-1,1,1,0,2));
      tbl.push_back(v(1,0,0,0,0,0,0, 0,-1,0,0,0,2));

      foreach (tbl[i]) begin
         reset = tbl[i].rst; go = tbl[i].g; direction = tbl[i].dir; wrap_en = tbl[i].wrap;
         start_reg = 5'(tbl[i].start); length = 6'(tbl[i].len); abort = tbl[i].abt;
         #1;
         chk_all(i, tbl[i].e_wr, tbl[i].e_reg, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_err, tbl[i].e_cnt);
         tick;
      end
      go = 1'b0; abort = 1'b0;

      // reset in the middle of a burst
      go = 1'b1; direction = 1'b1; wrap_en = 1'b0; start_reg = 5'd3; length = 6'd8;
      tick;
      go = 1'b0;
      tick;
      chk("mid wr_en", int'(wr_en), 1);
      chk("mid regnum", int'(regnum), 4);
      reset = 1'b0;
      tick;
      reset = 1'b1;
      chk_all(100, 0, 0, 0, 0, 0, 0);
      got_done = 0;
      for (int k = 0; k < 4; k++) begin
         if (done || wr_en) got_done = 1;
         tick;
      end
      chk("post reset quiet", got_done, 0);

      // bounded wait for a burst of three
      go = 1'b1; direction = 1'b1; start_reg = 5'd16; length = 6'd3;
      tick;
      go = 1'b0;
      writes = 0; got_done = 0;
      for (int k = 0; k < 20 && !got_done; k++) begin
         if (wr_en) writes++;
         if (done) got_done = 1;
         else tick;
      end
      chk("burst3 done seen", got_done, 1);
      chk("burst3 writes", writes, 3);
      chk("burst3 count", int'(count), 3);
      chk("burst3 err", int'(err), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
